// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-drive bundle between the word source and the select sequencer.
// The master is the word source; the slave is the sequencer that drives the mux.
interface mux_sel_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       pause;
    logic       abort;
    logic [7:0] d_out;
    logic       s2;
    logic       s1;
    logic       s0;
    logic       out_valid;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, data_in, pause, abort,
        input  in_ready, d_out, s2, s1, s0, out_valid, busy, done
    );

    modport slave (
        input  in_valid, data_in, pause, abort,
        output in_ready, d_out, s2, s1, s0, out_valid, busy, done
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Latches a word and steps the 8-to-1 mux select through all positions (parallel-to-serial).
// Latency: first select position visible the cycle after acceptance; RUN lasts 8*STEP_DIV clocks plus paused clocks.
// Backpressure: in_ready is low for the whole RUN; pause freezes select/divider. MSB_FIRST_EN selects d7..d0 order.
module mux_sel_sequencer #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_sequencer_if.slave  bus
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(STEP_DIV - 1);

`ifdef MSB_FIRST_EN
    localparam logic [2:0] SEL_FIRST = 3'b111;
    localparam logic [2:0] SEL_LAST  = 3'b000;
`else
    localparam logic [2:0] SEL_FIRST = 3'b000;
    localparam logic [2:0] SEL_LAST  = 3'b111;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      sel;
    logic [CW-1:0]   div_cnt;
    logic [7:0]      word;
    logic            out_valid_q;
    logic            busy_q;
    logic            done_q;
    logic [2:0]      sel_next;

`ifdef MSB_FIRST_EN
    assign sel_next = sel - 3'd1;
`else
    assign sel_next = sel + 3'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 3'b000;
            div_cnt     <= '0;
            word        <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word        <= bus.data_in;
                        sel         <= SEL_FIRST;
                        div_cnt     <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    // abort wins over pause and over the final-step completion
                    if (bus.abort) begin
                        div_cnt     <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (!bus.pause) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (sel == SEL_LAST) begin
                                // no wrap: select parks on the last position
                                done_q      <= 1'b1;
                                out_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                state       <= IDLE;
                            end else begin
                                sel <= sel_next;
                            end
                        end else begin
                            div_cnt <= div_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.d_out     = word;
    assign bus.s2        = sel[2];
    assign bus.s1        = sel[1];
    assign bus.s0        = sel[0];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
